// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared FSM states and width limits for the sequential multiplier
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/seq_multiplier_adder_n.sv
// rtl/seq_multiplier_adder_n.sv - width-generic ripple-carry adder with carry-out
module adder_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic carry;

    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add multiplier, fixed WIDTH+1 cycle latency
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("seq_multiplier: WIDTH out of legal range");
    end

    state_t             state, next_state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic               neg;

    logic               sm_eff;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               accept, last_iter;

    assign sm_eff    = SIGNED_EN && signed_mode;
    // Negating -2^(W-1) wraps to 2^(W-1), which is the correct unsigned magnitude
    assign a_mag     = (sm_eff && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (sm_eff && b[WIDTH-1]) ? -b : b;
    assign accept    = (state == IDLE) && in_valid;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    adder_n #(.WIDTH(WIDTH)) u_adder (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (mcand),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign acc_next = mplier[0] ? {add_cout, add_sum, acc[WIDTH-1:1]}
                                : {1'b0, acc[2*WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid)  next_state = CALC;
            CALC: if (last_iter) next_state = FIX;
            FIX:                 next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default:             next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            cnt     <= '0;
            mcand   <= a_mag;
            mplier  <= b_mag;
            acc     <= '0;
            neg     <= sm_eff && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state == CALC) begin
            cnt     <= cnt + CW'(1);
            mplier  <= mplier >> 1;
            acc     <= acc_next;
        end else if (state == FIX) begin
            // Negating a zero magnitude yields zero, so no negative zero escapes
            product <= neg ? -acc : acc;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier at WIDTH=4
module tb_seq_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           signed_mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;

    int checks = 0;
    int fails  = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] discard;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sm);
        int sx, sy;
        sx = (sm && x[W-1]) ? int'(x) - (1 << W) : int'(x);
        sy = (sm && y[W-1]) ? int'(y) - (1 << W) : int'(y);
        return (2*W)'(sx * sy);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        @(negedge clk);
        in_valid    = 1'b1;
        a           = x;
        b           = y;
        signed_mode = sm;
        exp_q.push_back(ref_mul(x, y, sm));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        logic [2*W-1:0] e;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 50);
        check({tag, "_latency"}, n, W + 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_product"}, product, e);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
    endtask

    initial begin
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(4'hF, 4'hF, 1'b0);
        check("accept_in_ready", in_ready, 0);
        wait_out("u15x15");
        check("u15x15_const", product, 8'hE1);
        release_out();

        start_op(4'h8, 4'h8, 1'b1);
        wait_out("s_m8xm8");
        check("s_m8xm8_const", product, 8'h40);
        release_out();
        start_op(4'h8, 4'h7, 1'b1);
        wait_out("s_m8x7");
        check("s_m8x7_const", product, 8'hC8);
        release_out();
        start_op(4'h0, 4'hF, 1'b1);
        wait_out("s_0xm1");
        check("s_0xm1_const", product, 8'h00);
        release_out();

        start_op(4'h7, 4'h3, 1'b0);
        wait_out("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a        = 4'(i);
            b        = 4'(15 - i);
            check("bp_out_valid", out_valid, 1);
            check("bp_product", product, 8'd21);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("bp_no_accept", in_ready, 1);

        start_op(4'h9, 4'h9, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_product", product, 0);
        check("midrst_in_ready", in_ready, 1);
        discard = exp_q.pop_back();
        @(negedge clk);
        rst_n = 1'b1;
        start_op(4'h3, 4'h5, 1'b0);
        wait_out("post_rst");
        check("post_rst_const", product, 8'd15);
        release_out();

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) begin
                start_op(4'(i >> 4), 4'(i), m[0]);
                wait_out(m[0] ? "exh_s" : "exh_u");
                release_out();
            end
        end

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
